// File: rtl/fft_bitrev_buffer_if.sv
// Handshake bundle for the FFT bit-reversal input buffer: the sample
// input stream and the butterfly operand-pair output stream.
interface fft_bitrev_buffer_if #(
    parameter int DW = 16
);
    logic [DW-1:0] i_re;
    logic [DW-1:0] i_im;
    logic          i_vld;
    logic          o_rdy_in;

    logic [DW-1:0] o_a_re;
    logic [DW-1:0] o_a_im;
    logic [DW-1:0] o_b_re;
    logic [DW-1:0] o_b_im;
    logic          o_vld;
    logic          i_rdy;
    logic [2:0]    o_pair_idx;
    logic          o_last;

    // Producer/consumer side (drives samples, accepts operand pairs)
    modport master (
        output i_re, i_im, i_vld, i_rdy,
        input  o_rdy_in, o_a_re, o_a_im, o_b_re, o_b_im,
               o_vld, o_pair_idx, o_last
    );

    // Buffer side
    modport slave (
        input  i_re, i_im, i_vld, i_rdy,
        output o_rdy_in, o_a_re, o_a_im, o_b_re, o_b_im,
               o_vld, o_pair_idx, o_last
    );
endinterface

// File: rtl/fft_bitrev_buffer.sv
// Ping-pong input buffer for the 16-point FFT. Samples arrive in natural
// order; each full frame leaves as 8 radix-2 butterfly operand pairs
// (x[p], x[p+8]) with p = bitrev3(k). One bank fills while the other drains.
// A bank is "occupied" while its full bit is set; the write counter tells
// EMPTY from FILLING and the read counter tells FULL from DRAINING.
module fft_bitrev_buffer #(
    parameter int DW  = 16,
    parameter int NPT = 16
) (
    input  logic               clk,
    input  logic               rst,
    fft_bitrev_buffer_if.slave bus
);
    localparam int AW = $clog2(NPT);
    localparam int KW = AW - 1;

    logic [2*DW-1:0] mem_q [0:1][0:NPT-1];

    logic          wr_bank_q, wr_bank_d;
    logic [AW-1:0] wr_cnt_q,  wr_cnt_d;
    logic          rd_bank_q, rd_bank_d;
    logic [KW-1:0] rd_cnt_q,  rd_cnt_d;
    logic [1:0]    full_q,    full_d;

    logic          wr_fire;
    logic          rd_fire;
    logic [KW-1:0] rd_p;
    logic [2*DW-1:0] rd_a;
    logic [2*DW-1:0] rd_b;

    assign wr_fire = bus.i_vld && !full_q[wr_bank_q];
    assign rd_fire = full_q[rd_bank_q] && bus.i_rdy;

    // Bit-reversed base index of the current pair
    assign rd_p = {rd_cnt_q[0], rd_cnt_q[1], rd_cnt_q[2]};

    // Next-state for write/read pointers and bank occupancy. A bank can only
    // be written while not full and read while full, so the two updates
    // below never target the same bank in one cycle.
    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_bank_d = rd_bank_q;
        rd_cnt_d  = rd_cnt_q;
        full_d    = full_q;
        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == AW'(NPT - 1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        if (rd_fire) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (rd_cnt_q == KW'(NPT / 2 - 1)) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
    end

    // Control state registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_cnt_q  <= '0;
            full_q    <= 2'b00;
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_bank_q <= rd_bank_d;
            rd_cnt_q  <= rd_cnt_d;
            full_q    <= full_d;
        end
    end

    // Sample storage; never reset because it is only visible while o_vld=1
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_cnt_q] <= {bus.i_re, bus.i_im};
        end
    end

    assign rd_a = mem_q[rd_bank_q][{1'b0, rd_p}];
    assign rd_b = mem_q[rd_bank_q][{1'b1, rd_p}];

    // All outputs derive from registered state, so they hold during stalls
    assign bus.o_rdy_in   = !full_q[wr_bank_q];
    assign bus.o_vld      = full_q[rd_bank_q];
    assign bus.o_a_re     = rd_a[2*DW-1:DW];
    assign bus.o_a_im     = rd_a[DW-1:0];
    assign bus.o_b_re     = rd_b[2*DW-1:DW];
    assign bus.o_b_im     = rd_b[DW-1:0];
    assign bus.o_pair_idx = rd_cnt_q;
    assign bus.o_last     = full_q[rd_bank_q] && (rd_cnt_q == KW'(NPT / 2 - 1));
endmodule

// File: doc/fft_bitrev_buffer.md
Name: fft_bitrev_buffer

Overview:
- Input stage of the 16-point FFT datapath. Collects 16 complex FP16 samples in natural order into a ping-pong buffer.
- Each full frame is issued as 8 stage-1 radix-2 DIT butterfly operand pairs, in bit-reversed order, to the butterfly add/subtract stage downstream.
- Double buffering lets one frame fill while the previous one drains.

Parameters:
- DW, 16, sample component width (FP16: sign, 5-bit exponent, 10-bit mantissa).
- NPT, 16, points per frame. Fixed at 16; other values are unsupported.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high; clears all state.
- i_re  input  DW  real part of input sample.
- i_im  input  DW  imaginary part of input sample.
- i_vld  input  1  input sample valid.
- o_rdy_in  output  1  buffer can accept a sample; transfer occurs when i_vld && o_rdy_in.
- o_a_re  output  DW  butterfly operand A, real part.
- o_a_im  output  DW  butterfly operand A, imaginary part.
- o_b_re  output  DW  butterfly operand B, real part.
- o_b_im  output  DW  butterfly operand B, imaginary part.
- o_vld  output  1  operand pair valid.
- i_rdy  input  1  downstream ready; pair transfers when o_vld && i_rdy.
- o_pair_idx  output  3  butterfly index k (0..7) of the current pair.
- o_last  output  1  high with pair k=7 of a frame.

Behaviour:
- Storage: two banks of 16 entries x 2*DW bits. Data passes through bit-exact; no arithmetic on sample values.
- Write side:
  - State is wr_bank (1b) and wr_cnt (4b).
  - An accepted sample is stored at bank[wr_bank][wr_cnt], then wr_cnt increments.
  - When wr_cnt=15 is accepted: wr_cnt wraps to 0, full[wr_bank] sets, wr_bank toggles.
  - o_rdy_in = !full[wr_bank]. It is combinational from registers and does not depend on i_vld.
- Read side:
  - State is rd_bank (1b) and rd_cnt (3b).
  - o_vld = full[rd_bank].
  - Pair k uses base index p = bitrev3(k), so k=0..7 gives p=0,4,2,6,1,5,3,7.
  - A = bank[rd_bank][p], B = bank[rd_bank][p+8].
  - o_pair_idx = rd_cnt; o_last = o_vld && (rd_cnt==7).
  - On each transfer, rd_cnt increments.
  - When rd_cnt=7 transfers: rd_cnt wraps to 0, full[rd_bank] clears, rd_bank toggles.
- Output stability: outputs are driven from registered state only. While o_vld=1 and i_rdy=0, all o_* outputs hold stable.
- Per-bank states:
  - EMPTY -> FILLING on the first write.
  - FILLING -> FULL on the 16th write.
  - FULL -> DRAINING on the first read.
  - DRAINING -> EMPTY on the 8th read.
  - The bank flag is full[]; EMPTY/FILLING and FULL/DRAINING are distinguished by the counters.
- Latency:
  - The 16th sample is accepted in cycle T; o_vld=1 in cycle T+1.
  - Minimum frame drain is 8 cycles with i_rdy held high.
  - Sustained throughput is 16 samples per 8 pair-cycles. The read side therefore never limits a continuous input stream.
- Boundary conditions:
  - Both banks full: o_rdy_in=0 and input stalls; no sample is overwritten or dropped.
  - Same-cycle fill completion on one bank and drain completion on the other: both take effect. The full bits of different banks update independently.
  - Drain completion on bank X while the writer waits on bank X: o_rdy_in rises the next cycle. There is no combinational ready-through path.
  - i_vld while o_rdy_in=0: ignored; write state is unchanged.
  - Reset, async at any time: wr_bank=rd_bank=0, wr_cnt=rd_cnt=0, full=2'b00, o_vld=0, o_last=0, o_pair_idx=0, o_rdy_in=1.
  - Reset mid-frame: the partial frame and any full frames are discarded. Storage contents need not be cleared, since they are never visible while o_vld=0.
  - Frames alternate banks strictly: bank 0, 1, 0, ...

Test Plan:
- Reset then 16 samples with i_re=16'h3C00+n and i_im=n (n=0..15), i_rdy=1 -> o_vld high the cycle after n=15. Pairs k=0..7 give A.re = 3C00+{0,4,2,6,1,5,3,7} and B.re = A.re+8. o_last only at k=7; o_vld drops after 8 transfers.
- Continuous stream of 64 samples with i_vld=1 and i_rdy=1 -> o_rdy_in never deasserts after reset. 4 frames emerge in order with correct bank alternation and no lost or duplicated pairs.
- i_rdy=0 throughout, 40 samples offered -> 32 samples accepted and o_rdy_in=0 thereafter. Raise i_rdy: frame 0 drains first; o_rdy_in returns 1 the cycle after its 8th pair transfers.
- Random i_rdy (50%) during drain, with o_vld=1 and i_rdy=0 held 3 cycles -> o_a_*, o_b_*, o_pair_idx and o_last remain constant across the stall.
- Assert rst asynchronously (mid-cycle) after 9 samples and during a drain at k=3 -> outputs go to reset values immediately. The next 16 samples form a clean frame starting at k=0.
- Special values 16'h7C00, 16'h8000 and 16'h0001 in the input -> passed bit-exact to the corresponding A/B slots.
